// File: rtl/ps2_host_if.sv
// Wishbone slave bus bundle for the PS/2 host controller.
interface ps2_host_if;
    logic        cyc_i;
    logic        stb_i;
    logic        we_i;
    logic [3:0]  sel_i;
    logic [1:0]  adr_i;
    logic [31:0] dat_i;
    logic [31:0] dat_o;
    logic        ack_o;

    modport master (
        output cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        input  dat_o, ack_o
    );

    modport slave (
        input  cyc_i, stb_i, we_i, sel_i, adr_i, dat_i,
        output dat_o, ack_o
    );
endinterface

// File: rtl/ps2_host.sv
// PS/2 host port: filtered RX with E0/F0 folding into an event FIFO,
// host-to-device TX, sticky error status and level interrupt.
module ps2_host #(
    parameter int FIFO_AW        = 4,
    parameter int FILTER_LEN     = 4,
    parameter int TIMEOUT_CYCLES = 50000,
    parameter int INHIBIT_CYCLES = 5000
) (
    input  logic      clk_i,
    input  logic      rst_i,
    input  logic      ps2_clk_i,
    input  logic      ps2_dat_i,
    output logic      ps2_clk_oe,
    output logic      ps2_dat_oe,
    ps2_host_if.slave bus,
    output logic      irq_o
);

    localparam int DEPTH = 1 << FIFO_AW;
    localparam int FW    = $clog2(FILTER_LEN + 1);
    localparam int TW    = $clog2(TIMEOUT_CYCLES + 1);
    localparam int IW    = $clog2(INHIBIT_CYCLES + 1);

    localparam logic [2:0] TX_IDLE    = 3'd0;
    localparam logic [2:0] TX_INHIBIT = 3'd1;
    localparam logic [2:0] TX_REQ     = 3'd2;
    localparam logic [2:0] TX_SHIFT   = 3'd3;
    localparam logic [2:0] TX_ACK     = 3'd4;
    localparam logic [2:0] TX_WAIT    = 3'd5;

    logic [1:0]    clk_sync, dat_sync;
    logic [FW-1:0] clk_run, dat_run;
    logic          clk_f, dat_f, clk_fall;

    logic [3:0]    rx_cnt;
    logic [8:0]    rx_sh;
    logic          byte_valid, rx_perr;
    logic [7:0]    rx_byte;

    logic [2:0]    tx_state;
    logic [8:0]    tx_sh;
    logic [3:0]    tx_cnt;
    logic [IW-1:0] inh_cnt;
    logic          tx_dat_oe, tx_nack_set;
    logic          tx_idle, tx_line;

    logic [TW-1:0] to_cnt;
    logic          to_active, to_hit;

    logic [9:0]         mem [DEPTH];
    logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
    logic [FIFO_AW:0]   count;
    logic               fifo_empty, fifo_full;
    logic               push_req, push, pop, flush;
    logic [9:0]         push_data;
    logic               brk_p, ext_p;

    logic        req, rd, wr;
    logic        tx_start, txovr_set, ovf_set;
    logic [4:0]  sticky, sticky_set, sticky_clr;
    logic        irq_en, raw_mode;
    logic [31:0] rdata;
    logic        unused_bits;

    assign unused_bits = &{1'b0, bus.sel_i, bus.dat_i[31:15], bus.dat_i[9:8]};

    // Two-flop synchroniser followed by a run-length filter per line.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            clk_sync <= 2'b11;
            dat_sync <= 2'b11;
            clk_run  <= '0;
            dat_run  <= '0;
            clk_f    <= 1'b1;
            dat_f    <= 1'b1;
            clk_fall <= 1'b0;
        end else begin
            clk_sync <= {clk_sync[0], ps2_clk_i};
            dat_sync <= {dat_sync[0], ps2_dat_i};
            clk_fall <= 1'b0;
            if (clk_sync[1] == clk_f) begin
                clk_run <= '0;
            end else if (clk_run == FW'(FILTER_LEN - 1)) begin
                clk_run  <= '0;
                clk_f    <= clk_sync[1];
                clk_fall <= ~clk_sync[1];
            end else begin
                clk_run <= clk_run + 1'b1;
            end
            if (dat_sync[1] == dat_f) begin
                dat_run <= '0;
            end else if (dat_run == FW'(FILTER_LEN - 1)) begin
                dat_run <= '0;
                dat_f   <= dat_sync[1];
            end else begin
                dat_run <= dat_run + 1'b1;
            end
        end
    end

    assign tx_idle = (tx_state == TX_IDLE);
    assign tx_line = (tx_state == TX_REQ) | (tx_state == TX_SHIFT) |
                     (tx_state == TX_ACK) | (tx_state == TX_WAIT);

    assign to_active = (rx_cnt != 4'd0) | tx_line;
    assign to_hit    = to_active & ~clk_fall &
                       (to_cnt == TW'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk_i) begin
        if (rst_i || !to_active || clk_fall || to_hit) begin
            to_cnt <= '0;
        end else begin
            to_cnt <= to_cnt + 1'b1;
        end
    end

    // rx_sh collects D0..D7 then parity, LSB first.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rx_cnt     <= 4'd0;
            rx_sh      <= 9'd0;
            rx_byte    <= 8'd0;
            byte_valid <= 1'b0;
            rx_perr    <= 1'b0;
        end else begin
            byte_valid <= 1'b0;
            rx_perr    <= 1'b0;
            if (!tx_idle || to_hit) begin
                rx_cnt <= 4'd0;
            end else if (clk_fall) begin
                case (rx_cnt)
                    4'd0: begin
                        if (!dat_f) rx_cnt <= 4'd1;
                    end
                    4'd10: begin
                        rx_cnt <= 4'd0;
                        if (dat_f && (^rx_sh)) begin
                            byte_valid <= 1'b1;
                            rx_byte    <= rx_sh[7:0];
                        end else begin
                            rx_perr <= 1'b1;
                        end
                    end
                    default: begin
                        rx_sh  <= {dat_f, rx_sh[8:1]};
                        rx_cnt <= rx_cnt + 4'd1;
                    end
                endcase
            end
        end
    end

    assign req       = bus.cyc_i & bus.stb_i & ~bus.ack_o;
    assign rd        = req & ~bus.we_i;
    assign wr        = req & bus.we_i;
    assign tx_start  = wr & (bus.adr_i == 2'd0) & tx_idle;
    assign txovr_set = wr & (bus.adr_i == 2'd0) & ~tx_idle;
    assign flush     = wr & (bus.adr_i == 2'd1) & bus.dat_i[0];

    assign fifo_empty = (count == '0);
    assign fifo_full  = (count == (FIFO_AW + 1)'(DEPTH));
    assign pop        = rd & (bus.adr_i == 2'd0) & ~fifo_empty;

    assign push_req = byte_valid &
                      (raw_mode | ((rx_byte != 8'hF0) & (rx_byte != 8'hE0)));
    assign push_data = raw_mode ? {2'b00, rx_byte} : {brk_p, ext_p, rx_byte};
    assign push      = push_req & ~fifo_full & ~flush;
    assign ovf_set   = push_req & fifo_full & ~flush;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            brk_p <= 1'b0;
            ext_p <= 1'b0;
        end else if (byte_valid) begin
            if (push_req) begin
                brk_p <= 1'b0;
                ext_p <= 1'b0;
            end else if (rx_byte == 8'hF0) begin
                brk_p <= 1'b1;
            end else begin
                ext_p <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (push) mem[wr_ptr] <= push_data;
    end

    always_ff @(posedge clk_i) begin
        if (rst_i || flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop) rd_ptr <= rd_ptr + 1'b1;
            count <= count + {{FIFO_AW{1'b0}}, push}
                           - {{FIFO_AW{1'b0}}, pop};
        end
    end

    // Bit 0 of the shift register is always the next bit to drive.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            tx_state    <= TX_IDLE;
            tx_sh       <= 9'd0;
            tx_cnt      <= 4'd0;
            inh_cnt     <= '0;
            tx_dat_oe   <= 1'b0;
            tx_nack_set <= 1'b0;
        end else begin
            tx_nack_set <= 1'b0;
            if (to_hit && tx_line) begin
                tx_state  <= TX_IDLE;
                tx_dat_oe <= 1'b0;
            end else begin
                case (tx_state)
                    TX_IDLE: begin
                        if (tx_start) begin
                            tx_sh    <= {~^bus.dat_i[7:0], bus.dat_i[7:0]};
                            inh_cnt  <= '0;
                            tx_state <= TX_INHIBIT;
                        end
                    end
                    TX_INHIBIT: begin
                        if (inh_cnt == IW'(INHIBIT_CYCLES - 1)) begin
                            tx_state  <= TX_REQ;
                            tx_dat_oe <= 1'b1;
                        end else begin
                            inh_cnt <= inh_cnt + 1'b1;
                        end
                    end
                    TX_REQ: begin
                        if (clk_fall) begin
                            tx_dat_oe <= ~tx_sh[0];
                            tx_sh     <= {1'b0, tx_sh[8:1]};
                            tx_cnt    <= 4'd1;
                            tx_state  <= TX_SHIFT;
                        end
                    end
                    TX_SHIFT: begin
                        if (clk_fall) begin
                            tx_cnt <= tx_cnt + 4'd1;
                            if (tx_cnt == 4'd9) begin
                                tx_dat_oe <= 1'b0;
                                tx_state  <= TX_ACK;
                            end else begin
                                tx_dat_oe <= ~tx_sh[0];
                                tx_sh     <= {1'b0, tx_sh[8:1]};
                            end
                        end
                    end
                    TX_ACK: begin
                        if (clk_fall) begin
                            tx_nack_set <= dat_f;
                            tx_state    <= TX_WAIT;
                        end
                    end
                    TX_WAIT: begin
                        if (clk_f && dat_f) tx_state <= TX_IDLE;
                    end
                    default: tx_state <= TX_IDLE;
                endcase
            end
        end
    end

    assign ps2_clk_oe = (tx_state == TX_INHIBIT);
    assign ps2_dat_oe = tx_dat_oe;

    // Sticky order matches status bits 14:10.
    assign sticky_set = {txovr_set, to_hit, tx_nack_set, ovf_set, rx_perr};
    assign sticky_clr = (wr && bus.adr_i == 2'd1) ? bus.dat_i[14:10] : 5'd0;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            sticky <= 5'd0;
        end else begin
            sticky <= (sticky & ~sticky_clr) | sticky_set;
        end
    end

    always_comb begin
        rdata = 32'd0;
        case (bus.adr_i)
            2'd0: if (!fifo_empty) rdata = {1'b1, 21'd0, mem[rd_ptr]};
            2'd1: rdata = {17'd0, sticky, ~tx_idle, fifo_full, 8'(count)};
            2'd2: rdata = {30'd0, raw_mode, irq_en};
            default: rdata = 32'd0;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            bus.ack_o <= 1'b0;
            bus.dat_o <= 32'd0;
            irq_en    <= 1'b0;
            raw_mode  <= 1'b0;
            irq_o     <= 1'b0;
        end else begin
            bus.ack_o <= req;
            if (req) bus.dat_o <= rdata;
            if (wr && bus.adr_i == 2'd2) begin
                irq_en   <= bus.dat_i[0];
                raw_mode <= bus.dat_i[1];
            end
            irq_o <= irq_en & (~fifo_empty | (|sticky));
        end
    end

endmodule

// File: tb/tb_ps2_host.sv
// Bench for ps2_host: PS/2 device model, Wishbone master tasks and
// a queue-based event model of the prefix decoder and FIFO.
module tb_ps2_host;

    localparam int DEPTH = 4;
    localparam int TO    = 200;
    localparam int INH   = 20;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic dev_clk_low = 1'b0;
    logic dev_dat_low = 1'b0;
    logic ps2_clk_oe, ps2_dat_oe, irq;
    logic ps2_clk_line, ps2_dat_line;

    int n_chk = 0;
    int n_fail = 0;

    bit          m_raw = 1'b0;
    bit          m_brk = 1'b0;
    bit          m_ext = 1'b0;
    bit          m_ovf = 1'b0;
    logic [31:0] m_q[$];

    ps2_host_if bus();

    assign ps2_clk_line = ~(ps2_clk_oe | dev_clk_low);
    assign ps2_dat_line = ~(ps2_dat_oe | dev_dat_low);

    ps2_host #(
        .FIFO_AW(2), .FILTER_LEN(2),
        .TIMEOUT_CYCLES(TO), .INHIBIT_CYCLES(INH)
    ) dut (
        .clk_i(clk), .rst_i(rst),
        .ps2_clk_i(ps2_clk_line), .ps2_dat_i(ps2_dat_line),
        .ps2_clk_oe(ps2_clk_oe), .ps2_dat_oe(ps2_dat_oe),
        .bus(bus), .irq_o(irq)
    );

    always #5 clk = ~clk;

    initial begin
        #600000;
        $display("FAIL watchdog: got no finish want finish");
        $fatal(1);
    end

    function automatic bit odd_par(input logic [7:0] b);
        return ($countones(b) % 2) == 0;
    endfunction

    // Decoder rules: prefixes become pending flags, others are events.
    function automatic void model_byte(input logic [7:0] b);
        logic [31:0] ev;
        if (!m_raw && b == 8'hF0) begin
            m_brk = 1'b1;
            return;
        end
        if (!m_raw && b == 8'hE0) begin
            m_ext = 1'b1;
            return;
        end
        ev = m_raw ? 32'h8000_0000 + b
                   : 32'h8000_0000 + (m_brk ? 512 : 0) + (m_ext ? 256 : 0) + b;
        if (m_q.size() == DEPTH) m_ovf = 1'b1;
        else m_q.push_back(ev);
        m_brk = 1'b0;
        m_ext = 1'b0;
    endfunction

    task automatic wb_rd(input logic [1:0] a, output logic [31:0] d);
        int n;
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b0;
        bus.adr_i = a; bus.sel_i = 4'hf;
        d = 32'd0; n = 0;
        do begin @(negedge clk); n++; end while (!bus.ack_o && n < 8);
        if (bus.ack_o) d = bus.dat_o;
        else begin
            n_chk++; n_fail++;
            $display("FAIL wb_rd_ack: got 0 want 1");
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0;
    endtask

    task automatic wb_wr(input logic [1:0] a, input logic [31:0] d);
        int n;
        @(negedge clk);
        bus.cyc_i = 1'b1; bus.stb_i = 1'b1; bus.we_i = 1'b1;
        bus.adr_i = a; bus.dat_i = d; bus.sel_i = 4'hf;
        n = 0;
        do begin @(negedge clk); n++; end while (!bus.ack_o && n < 8);
        if (!bus.ack_o) begin
            n_chk++; n_fail++;
            $display("FAIL wb_wr_ack: got 0 want 1");
        end
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
    endtask

    // Device-to-host frame at 40 clk_i cycles per bit.
    task automatic dev_send(input logic [7:0] b, input bit flip, input int nbits);
        logic [10:0] fr;
        fr = {1'b1, odd_par(b) ^ flip, b, 1'b0};
        for (int i = 0; i < nbits; i++) begin
            dev_dat_low = ~fr[i];
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            repeat (10) @(negedge clk);
        end
        dev_dat_low = 1'b0;
        repeat (10) @(negedge clk);
    endtask

    // Host-to-device frame; the device samples data on rising clock.
    task automatic dev_recv(input bit ack_low, output logic [7:0] b,
                            output logic p, output logic stp);
        int n;
        logic [10:0] bits;
        n = 0; bits = '0;
        while (!(ps2_clk_oe == 1'b0 && ps2_dat_oe == 1'b1) && n < 2000) begin
            @(negedge clk); n++;
        end
        if (n >= 2000) begin
            n_chk++; n_fail++;
            $display("FAIL dev_recv_req: got no request want request");
        end
        for (int k = 1; k <= 10; k++) begin
            repeat (10) @(negedge clk);
            dev_clk_low = 1'b1;
            repeat (20) @(negedge clk);
            dev_clk_low = 1'b0;
            bits[k] = ps2_dat_line;
            repeat (10) @(negedge clk);
        end
        dev_dat_low = ack_low;
        repeat (10) @(negedge clk);
        dev_clk_low = 1'b1;
        repeat (20) @(negedge clk);
        dev_clk_low = 1'b0;
        repeat (5) @(negedge clk);
        dev_dat_low = 1'b0;
        repeat (20) @(negedge clk);
        b = bits[8:1]; p = bits[9]; stp = bits[10];
    endtask

    task automatic drain_check(input string nm);
        logic [31:0] d, e;
        int sz;
        sz = m_q.size();
        for (int i = 0; i <= sz; i++) begin
            e = (m_q.size() != 0) ? m_q.pop_front() : 32'd0;
            wb_rd(2'd0, d);
            n_chk++;
            if (d !== e) begin
                n_fail++;
                $display("FAIL %s_read%0d: got %h want %h", nm, i, d, e);
            end
        end
    endtask

    task automatic test_reset();
        logic [31:0] d;
        rst = 1'b1;
        repeat (3) @(negedge clk);
        n_chk++;
        if ({bus.ack_o, irq, ps2_clk_oe, ps2_dat_oe} !== 4'b0) begin
            n_fail++;
            $display("FAIL reset_outs: got %b want 0000",
                     {bus.ack_o, irq, ps2_clk_oe, ps2_dat_oe});
        end
        n_chk++;
        if (bus.dat_o !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_dat_o: got %h want 0", bus.dat_o);
        end
        rst = 1'b0;
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL reset_status: got %h want 0", d);
        end
        wb_rd(2'd2, d);
        n_chk++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL reset_ctrl: got %h want 0", d);
        end
        wb_wr(2'd3, 32'hffff_ffff);
        wb_rd(2'd3, d);
        n_chk++;
        if (d !== 32'd0) begin
            n_fail++; $display("FAIL adr3_read: got %h want 0", d);
        end
    endtask

    task automatic test_rx_single();
        logic [31:0] d;
        dev_send(8'h1C, 1'b0, 11);
        model_byte(8'h1C);
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL rx_usedw: got %h want 1", d);
        end
        drain_check("rx_single");
    endtask

    task automatic test_prefix();
        logic [31:0] d;
        logic [7:0] seq [3];
        seq = '{8'hE0, 8'hF0, 8'h75};
        for (int i = 0; i < 3; i++) begin
            dev_send(seq[i], 1'b0, 11);
            model_byte(seq[i]);
        end
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'h1) begin
            n_fail++; $display("FAIL prefix_usedw: got %h want 1", d);
        end
        n_chk++;
        if (m_q[0] !== 32'h8000_0375) begin
            n_fail++; $display("FAIL prefix_model: got %h want 80000375", m_q[0]);
        end
        drain_check("prefix");
        wb_wr(2'd2, 32'h2);
        m_raw = 1'b1;
        for (int i = 0; i < 3; i++) begin
            dev_send(seq[i], 1'b0, 11);
            model_byte(seq[i]);
        end
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'h3) begin
            n_fail++; $display("FAIL raw_usedw: got %h want 3", d);
        end
        drain_check("raw");
        wb_wr(2'd2, 32'h0);
        m_raw = 1'b0;
    endtask

    task automatic test_random_rx();
        logic [7:0] b;
        for (int r = 0; r < 3; r++) begin
            m_raw = ($urandom_range(0, 1) == 1);
            wb_wr(2'd2, m_raw ? 32'h2 : 32'h0);
            for (int i = 0; i < 3; i++) begin
                case ($urandom_range(0, 3))
                    0: b = 8'hE0;
                    1: b = 8'hF0;
                    default: b = 8'($urandom);
                endcase
                dev_send(b, 1'b0, 11);
                model_byte(b);
            end
            drain_check("random_rx");
        end
        m_raw = 1'b0;
        wb_wr(2'd2, 32'h0);
        dev_send(8'h11, 1'b0, 11);
        model_byte(8'h11);
        drain_check("random_tail");
    endtask

    task automatic test_overflow();
        logic [31:0] d, e;
        logic [7:0] b;
        for (int i = 0; i < 5; i++) begin
            b = 8'($urandom_range(1, 8'hDF));
            dev_send(b, 1'b0, 11);
            model_byte(b);
        end
        e = m_q.size() + ((m_q.size() == DEPTH) ? 32'h100 : 0) + (m_ovf ? 32'h800 : 0);
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== e || e !== 32'h904) begin
            n_fail++; $display("FAIL ovf_status: got %h want %h", d, e);
        end
        wb_wr(2'd1, 32'h800);
        m_ovf = 1'b0;
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'h104) begin
            n_fail++; $display("FAIL ovf_clear: got %h want 104", d);
        end
        drain_check("ovf");
        dev_send(8'h33, 1'b0, 11);
        dev_send(8'h34, 1'b0, 11);
        wb_wr(2'd1, 32'h1);
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL flush: got %h want 0", d);
        end
    endtask

    task automatic test_parity_irq();
        logic [31:0] d;
        wb_wr(2'd2, 32'h1);
        dev_send(8'h1C, 1'b1, 11);
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'h400) begin
            n_fail++; $display("FAIL parity_status: got %h want 400", d);
        end
        n_chk++;
        if (irq !== 1'b1) begin
            n_fail++; $display("FAIL irq_set: got %b want 1", irq);
        end
        wb_wr(2'd1, 32'h400);
        repeat (2) @(negedge clk);
        n_chk++;
        if (irq !== 1'b0) begin
            n_fail++; $display("FAIL irq_clear: got %b want 0", irq);
        end
        wb_wr(2'd2, 32'h0);
    endtask

    task automatic test_tx();
        logic [31:0] d;
        logic [7:0] rb;
        logic rp, rs;
        int n;
        wb_wr(2'd0, 32'hED);
        n = 0;
        while (ps2_clk_oe && n < 100) begin
            n++; @(negedge clk);
        end
        n_chk++;
        if (n != INH) begin
            n_fail++; $display("FAIL tx_inhibit_len: got %0d want %0d", n, INH);
        end
        n_chk++;
        if (ps2_dat_oe !== 1'b1) begin
            n_fail++; $display("FAIL tx_start_bit: got %b want 1", ps2_dat_oe);
        end
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'h200) begin
            n_fail++; $display("FAIL tx_busy: got %h want 200", d);
        end
        wb_wr(2'd0, 32'h55);
        dev_recv(1'b1, rb, rp, rs);
        n_chk++;
        if ({rb, rp, rs} !== {8'hED, odd_par(8'hED), 1'b1}) begin
            n_fail++;
            $display("FAIL tx_frame: got %h/%b/%b want ed/%b/1", rb, rp, rs, odd_par(8'hED));
        end
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'h4000) begin
            n_fail++; $display("FAIL tx_done: got %h want 4000", d);
        end
        wb_wr(2'd1, 32'h7C00);
    endtask

    task automatic test_tx_random();
        logic [31:0] d;
        logic [7:0] b, rb;
        logic rp, rs;
        bit ackl;
        for (int r = 0; r < 2; r++) begin
            b = 8'($urandom);
            ackl = (r == 0) ? 1'b0 : 1'($urandom_range(0, 1));
            wb_wr(2'd0, {24'd0, b});
            dev_recv(ackl, rb, rp, rs);
            n_chk++;
            if ({rb, rp, rs} !== {b, odd_par(b), 1'b1}) begin
                n_fail++;
                $display("FAIL txr_frame: got %h/%b/%b want %h/%b/1", rb, rp, rs, b, odd_par(b));
            end
            wb_rd(2'd1, d);
            n_chk++;
            if (d !== (ackl ? 32'h0 : 32'h1000)) begin
                n_fail++;
                $display("FAIL txr_nack: got %h want %h", d, ackl ? 32'h0 : 32'h1000);
            end
            wb_wr(2'd1, 32'h7C00);
        end
    endtask

    task automatic test_timeout();
        logic [31:0] d;
        dev_send(8'h5A, 1'b0, 4);
        repeat (TO + 50) @(negedge clk);
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'h2000) begin
            n_fail++; $display("FAIL rx_timeout: got %h want 2000", d);
        end
        wb_wr(2'd1, 32'h2000);
        dev_send(8'h2A, 1'b0, 11);
        model_byte(8'h2A);
        drain_check("after_timeout");
    endtask

    task automatic test_reset_tx();
        logic [31:0] d;
        wb_wr(2'd0, 32'hF4);
        repeat (3) @(negedge clk);
        n_chk++;
        if (ps2_clk_oe !== 1'b1) begin
            n_fail++; $display("FAIL rst_tx_inhibit: got %b want 1", ps2_clk_oe);
        end
        rst = 1'b1;
        @(posedge clk);
        #1;
        n_chk++;
        if ({ps2_clk_oe, ps2_dat_oe} !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_tx_release: got %b want 00", {ps2_clk_oe, ps2_dat_oe});
        end
        @(negedge clk);
        rst = 1'b0;
        m_brk = 1'b0; m_ext = 1'b0; m_q.delete();
        wb_rd(2'd1, d);
        n_chk++;
        if (d !== 32'h0) begin
            n_fail++; $display("FAIL rst_tx_status: got %h want 0", d);
        end
    endtask

    initial begin
        bus.cyc_i = 1'b0; bus.stb_i = 1'b0; bus.we_i = 1'b0;
        bus.sel_i = 4'h0; bus.adr_i = 2'd0; bus.dat_i = 32'd0;
        test_reset();
        test_rx_single();
        test_prefix();
        test_random_rx();
        test_overflow();
        test_parity_irq();
        test_tx();
        test_tx_random();
        test_timeout();
        test_reset_tx();
        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
